// File: rtl/gcn_seq_engine_if.sv
// Handshake and memory bus bundle for gcn_seq_engine: edge input, feature/weight reads, result output.
interface gcn_seq_engine_if #(
  parameter int N_NODES = 6,
  parameter int N_FEAT  = 96,
  parameter int N_CLASS = 3,
  parameter int BW      = 5,
  parameter int LANES   = 8
);
  localparam int CH  = N_FEAT / LANES;
  localparam int NW  = $clog2(N_NODES + 1);
  localparam int NDW = $clog2(N_NODES);
  localparam int CLW = $clog2(N_CLASS);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic                  start;
  logic                  edge_valid;
  logic                  edge_ready;
  logic [NW-1:0]         edge_src;
  logic [NW-1:0]         edge_dst;
  logic                  rd_en;
  logic [NDW-1:0]        rd_node;
  logic [CLW-1:0]        rd_class;
  logic [CHW-1:0]        rd_chunk;
  logic [LANES*BW-1:0]   fm_rdata;
  logic [LANES*BW-1:0]   wm_rdata;
  logic                  y_valid;
  logic                  y_ready;
  logic [NDW-1:0]        y_node;
  logic [CLW-1:0]        y_class;
  logic                  busy;
  logic                  done;
  logic                  edge_err;

  modport slave (
    input  start, edge_valid, edge_src, edge_dst, fm_rdata, wm_rdata, y_ready,
    output edge_ready, rd_en, rd_node, rd_class, rd_chunk, y_valid, y_node, y_class,
           busy, done, edge_err
  );

  modport master (
    output start, edge_valid, edge_src, edge_dst, fm_rdata, wm_rdata, y_ready,
    input  edge_ready, rd_en, rd_node, rd_class, rd_chunk, y_valid, y_node, y_class,
           busy, done, edge_err
  );
endinterface

// File: rtl/gcn_seq_engine.sv
// Sequential single-layer GCN classifier: COO edges -> X*W transform -> A*T aggregation -> per-node argmax.
// Optional macro GCN_SELF_LOOP_EN seeds the adjacency diagonal at job start (A+I aggregation).
module gcn_seq_engine #(
  parameter int N_NODES = 6,
  parameter int N_FEAT  = 96,
  parameter int N_CLASS = 3,
  parameter int BW      = 5,
  parameter int N_EDGES = 6,
  parameter int LANES   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  gcn_seq_engine_if.slave bus
);
  localparam int CH    = N_FEAT / LANES;
  localparam int NW    = $clog2(N_NODES + 1);
  localparam int NDW   = $clog2(N_NODES);
  localparam int CLW   = $clog2(N_CLASS);
  localparam int CHW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int ECW   = $clog2(N_EDGES + 1);
  localparam int ACC_W = 2 * BW + $clog2(N_FEAT + 1);
  localparam int OW    = ACC_W + $clog2(N_NODES + 1);

  typedef enum logic [2:0] {IDLE, EDGES, XFORM, AGG, OUT} state_t;

  state_t state_q, state_d;

  logic [N_NODES-1:0] adj_q [N_NODES];
  logic [ACC_W-1:0]   t_q   [N_NODES][N_CLASS];
  logic [CLW-1:0]     cls_q [N_NODES];

  logic [ECW-1:0] edgeCnt_q;
  logic [NDW-1:0] rdNode_q, aggNode_q, outNode_q, pendNode_q;
  logic [CLW-1:0] rdClass_q, pendClass_q;
  logic [CHW-1:0] rdChunk_q;
  logic           issueDone_q, pend_q, pendLast_q, edgeErr_q, done_q;

  logic           startHit, edgeFire, edgeLegal, lastEdge;
  logic           rdFire, lastChunk, lastClass, lastRead;
  logic           aggLast, outLast, yFire;
  logic [NDW-1:0] srcIdx, dstIdx;
  logic [ACC_W-1:0] dot;
  logic [OW-1:0]    oRow [N_CLASS];
  logic [OW-1:0]    best;
  logic [CLW-1:0]   bestIdx;

  assign startHit  = bus.start && (state_q == IDLE);
  assign edgeFire  = bus.edge_valid && (state_q == EDGES);
  assign edgeLegal = (bus.edge_src != '0) && (bus.edge_src <= NW'(N_NODES)) &&
                     (bus.edge_dst != '0) && (bus.edge_dst <= NW'(N_NODES));
  assign srcIdx    = NDW'(bus.edge_src - NW'(1));
  assign dstIdx    = NDW'(bus.edge_dst - NW'(1));
  assign lastEdge  = (edgeCnt_q == ECW'(N_EDGES - 1));
  assign rdFire    = (state_q == XFORM) && !issueDone_q;
  assign lastChunk = (rdChunk_q == CHW'(CH - 1));
  assign lastClass = (rdClass_q == CLW'(N_CLASS - 1));
  assign lastRead  = lastChunk && lastClass && (rdNode_q == NDW'(N_NODES - 1));
  assign aggLast   = (aggNode_q == NDW'(N_NODES - 1));
  assign outLast   = (outNode_q == NDW'(N_NODES - 1));
  assign yFire     = (state_q == OUT) && bus.y_ready;

  // Lane-parallel dot product of the returned feature and weight chunks.
  always_comb begin
    dot = '0;
    for (int l = 0; l < LANES; l++) begin
      dot = dot + ACC_W'(bus.fm_rdata[l*BW +: BW]) * ACC_W'(bus.wm_rdata[l*BW +: BW]);
    end
  end

  // One aggregated row per cycle; strict '>' keeps the lowest class on ties.
  always_comb begin
    for (int j = 0; j < N_CLASS; j++) begin
      oRow[j] = '0;
      for (int k = 0; k < N_NODES; k++) begin
        if (adj_q[aggNode_q][k]) oRow[j] = oRow[j] + OW'(t_q[k][j]);
      end
    end
    best    = oRow[0];
    bestIdx = '0;
    for (int j = 1; j < N_CLASS; j++) begin
      if (oRow[j] > best) begin
        best    = oRow[j];
        bestIdx = CLW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.edge_ready = 1'b0;
    bus.y_valid    = 1'b0;
    bus.y_class    = '0;
    case (state_q)
      IDLE:  if (bus.start) state_d = EDGES;
      EDGES: begin
        bus.edge_ready = 1'b1;
        if (edgeFire && lastEdge) state_d = XFORM;
      end
      XFORM: if (pend_q && pendLast_q) state_d = AGG;
      AGG:   if (aggLast) state_d = OUT;
      OUT: begin
        bus.y_valid = 1'b1;
        bus.y_class = cls_q[outNode_q];
        if (bus.y_ready && outLast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    bus.rd_en    = rdFire;
    bus.rd_node  = rdNode_q;
    bus.rd_class = rdClass_q;
    bus.rd_chunk = rdChunk_q;
    bus.y_node   = outNode_q;
    bus.busy     = (state_q != IDLE);
    bus.done     = done_q;
    bus.edge_err = edgeErr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NODES; i++) begin
        adj_q[i] <= '0;
        cls_q[i] <= '0;
        for (int j = 0; j < N_CLASS; j++) t_q[i][j] <= '0;
      end
      edgeCnt_q   <= '0;
      rdNode_q    <= '0;
      rdClass_q   <= '0;
      rdChunk_q   <= '0;
      aggNode_q   <= '0;
      outNode_q   <= '0;
      pendNode_q  <= '0;
      pendClass_q <= '0;
      issueDone_q <= 1'b0;
      pend_q      <= 1'b0;
      pendLast_q  <= 1'b0;
      edgeErr_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= yFire && outLast;
      pend_q      <= rdFire;
      pendLast_q  <= rdFire && lastRead;
      pendNode_q  <= rdNode_q;
      pendClass_q <= rdClass_q;

      if (startHit) begin
        for (int i = 0; i < N_NODES; i++) begin
`ifdef GCN_SELF_LOOP_EN
          adj_q[i] <= N_NODES'(1) << i;
`else
          adj_q[i] <= '0;
`endif
          cls_q[i] <= '0;
          for (int j = 0; j < N_CLASS; j++) t_q[i][j] <= '0;
        end
        edgeCnt_q   <= '0;
        aggNode_q   <= '0;
        outNode_q   <= '0;
        issueDone_q <= 1'b0;
        edgeErr_q   <= 1'b0;
      end

      // Illegal endpoints still consume an edge slot so the job length stays fixed.
      if (edgeFire) begin
        edgeCnt_q <= lastEdge ? '0 : edgeCnt_q + ECW'(1);
        if (edgeLegal) begin
          adj_q[srcIdx][dstIdx] <= 1'b1;
          adj_q[dstIdx][srcIdx] <= 1'b1;
        end else begin
          edgeErr_q <= 1'b1;
        end
      end

      if (rdFire) begin
        if (lastChunk) begin
          rdChunk_q <= '0;
          if (lastClass) begin
            rdClass_q <= '0;
            rdNode_q  <= lastRead ? '0 : rdNode_q + NDW'(1);
          end else begin
            rdClass_q <= rdClass_q + CLW'(1);
          end
        end else begin
          rdChunk_q <= rdChunk_q + CHW'(1);
        end
        if (lastRead) issueDone_q <= 1'b1;
      end

      if (pend_q && (state_q == XFORM))
        t_q[pendNode_q][pendClass_q] <= t_q[pendNode_q][pendClass_q] + dot;

      if (state_q == AGG) begin
        cls_q[aggNode_q] <= bestIdx;
        aggNode_q        <= aggLast ? '0 : aggNode_q + NDW'(1);
      end

      if (yFire) outNode_q <= outLast ? '0 : outNode_q + NDW'(1);
    end
  end
endmodule

// File: doc/gcn_seq_engine.md
GCN_SEQ_ENGINE -- requirements
Module: gcn_seq_engine

Interface
REQ-001 Parameter N_NODES, default 6: graph node count, 2..64.
REQ-002 Parameter N_FEAT, default 96: features per node.
REQ-003 Parameter N_CLASS, default 3: output classes, 2..8.
REQ-004 Parameter BW, default 5: unsigned feature/weight element width.
REQ-005 Parameter N_EDGES, default 6: COO edges per graph.
REQ-006 Parameter LANES, default 8: elements multiplied per cycle; N_FEAT % LANES == 0; CH = N_FEAT/LANES.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 start  in  1  one-cycle pulse; begins a graph job.
REQ-010 edge_valid/edge_ready  in/out  1/1  COO edge handshake.
REQ-011 edge_src, edge_dst  in  NW each  1-based node indices; NW = $clog2(N_NODES+1).
REQ-012 rd_en  out  1  read strobe to feature and weight memories.
REQ-013 rd_node  out  $clog2(N_NODES)  feature row; rd_class  out  $clog2(N_CLASS)  weight row; rd_chunk  out  $clog2(CH)  lane chunk.
REQ-014 fm_rdata, wm_rdata  in  LANES*BW each  chunk data, valid exactly 1 cycle after rd_en; lane l at bits [l*BW +: BW].
REQ-015 y_valid/y_ready  out/in  1/1  result handshake; y_node  out  $clog2(N_NODES); y_class  out  $clog2(N_CLASS).
REQ-016 busy  out  1; done  out  1  one-cycle pulse; edge_err  out  1  sticky per job.

Function
REQ-017 FSM states IDLE, EDGES, XFORM, AGG, OUT; start in IDLE -> EDGES, clears adjacency, transform/aggregate storage, edge_err.
REQ-018 start outside IDLE is ignored.
REQ-019 EDGES: edge_ready=1; each accepted edge (s,d) sets adj[s-1][d-1] and adj[d-1][s-1]; duplicates idempotent; after N_EDGES accepts -> XFORM.
REQ-020 Edge with src or dst equal to 0 or > N_NODES: accepted, counted, adjacency unchanged, edge_err set.
REQ-021 XFORM: issues rd_en once per cycle over (node, class, chunk), chunk fastest, then class, then node; CH*N_CLASS*N_NODES reads.
REQ-022 Each returned chunk adds sum of LANES products fm*wm into T[node][class]; ACC_W = 2*BW + $clog2(N_FEAT+1); no overflow possible.
REQ-023 XFORM -> AGG one cycle after the last read's data is accumulated.
REQ-024 AGG: one node i per cycle, O[i][j] = sum_k adj[i][k]*T[k][j] for all j; width ACC_W + $clog2(N_NODES+1); N_NODES cycles -> OUT.
REQ-025 OUT: presents node 0..N_NODES-1 in order; y_class = argmax_j O[i][j]; ties resolve to lowest j; all-zero row gives 0.
REQ-026 y_node/y_class held stable while y_valid=1 and y_ready=0; advance only on y_valid&&y_ready.
REQ-027 After final handshake: done pulses 1 cycle, FSM -> IDLE, busy falls same cycle done is high.
REQ-028 busy=1 in every state except IDLE.

Reset
REQ-029 rst_n low at any time, including mid-job: FSM -> IDLE, counters 0, adjacency cleared; outputs edge_ready, rd_en, y_valid, busy, done, edge_err = 0; rd_node, rd_class, rd_chunk, y_node, y_class = 0.
REQ-030 Read data returning after a mid-job reset is discarded.

Configuration
REQ-031 Macro GCN_SELF_LOOP_EN defined: adj[i][i]=1 for all i at job start (A+I aggregation); undefined: diagonal set only by self-edges (s==d).

Verification
REQ-032 Defaults, edges (1,2),(2,3),(3,4),(4,5),(5,6),(6,1), all fm=1, wm class1=2 else 1 -> every y_class=1; done 1 cycle after 6th y handshake.
REQ-033 Default, full reads: first rd_en exactly 1 cycle after 6th edge accepted; rd_en high for 6*3*12=216 consecutive cycles.
REQ-034 Edge (0,3) and (7,2) among 6 -> edge_err=1; adjacency holds only the 4 legal edges; job completes.
REQ-035 O row equal in classes 0 and 2 -> y_class=0; y_ready held low 5 cycles during OUT -> y_node/y_class unchanged.
REQ-036 rst_n asserted mid-XFORM -> all outputs 0 next edge; new start runs full job with correct results.
REQ-037 Isolated node 4, GCN_SELF_LOOP_EN undefined -> y_class=0; defined -> argmax of T[3].
